// File: rtl/axi_lite_cmd_engine.sv
// Transaction engine of the AXI-Lite master: pops one command word, runs it as a single
// AXI4-Lite read or write, then pushes one response word. Commands are handled one at a time.
module axi_lite_cmd_engine #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CMD_WIDTH  = 1 + ADDR_WIDTH + DATA_WIDTH,
   parameter int unsigned RSP_WIDTH  = 2 + DATA_WIDTH
) (
   input  logic                      aclk,
   input  logic                      resetn,
   input  logic [CMD_WIDTH-1:0]      cmd_rdata_i,
   input  logic                      cmd_empty_i,
   output logic                      cmd_read_o,
   output logic [RSP_WIDTH-1:0]      rsp_wdata_o,
   output logic                      rsp_write_o,
   input  logic                      rsp_full_i,
   output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
   output logic [2:0]                m_axi_awprot,
   output logic                      m_axi_awvalid,
   input  logic                      m_axi_awready,
   output logic [DATA_WIDTH-1:0]     m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
   output logic                      m_axi_wvalid,
   input  logic                      m_axi_wready,
   input  logic [1:0]                m_axi_bresp,
   input  logic                      m_axi_bvalid,
   output logic                      m_axi_bready,
   output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
   output logic [2:0]                m_axi_arprot,
   output logic                      m_axi_arvalid,
   input  logic                      m_axi_arready,
   input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
   input  logic [1:0]                m_axi_rresp,
   input  logic                      m_axi_rvalid,
   output logic                      m_axi_rready,
   output logic                      busy_o,
   output logic [15:0]               txn_count_o,
   output logic [15:0]               err_count_o
);

   typedef enum logic [2:0] {
      StIdle, StFetch, StWaddr, StWresp, StRaddr, StRdata, StPush
   } state_e;

   state_e                r_state;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [RSP_WIDTH-1:0]  r_rsp;
   logic                  r_cmd_read;
   logic                  r_busy;
   logic                  r_awvalid;
   logic                  r_wvalid;
   logic                  r_bready;
   logic                  r_arvalid;
   logic                  r_rready;
   logic [15:0]           r_txn_cnt;
   logic [15:0]           r_err_cnt;

   logic w_aw_done;
   logic w_w_done;
   logic w_push;

   // A channel counts as done once its valid has already dropped or handshakes at this edge.
   assign w_aw_done = !r_awvalid || m_axi_awready;
   assign w_w_done  = !r_wvalid  || m_axi_wready;
   // Push is qualified live by full so a late full never causes an overwrite.
   assign w_push    = (r_state == StPush) && !rsp_full_i;

   always_ff @(posedge aclk) begin
      if (!resetn) begin
         r_state    <= StIdle;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_rsp      <= '0;
         r_cmd_read <= 1'b0;
         r_busy     <= 1'b0;
         r_awvalid  <= 1'b0;
         r_wvalid   <= 1'b0;
         r_bready   <= 1'b0;
         r_arvalid  <= 1'b0;
         r_rready   <= 1'b0;
         r_txn_cnt  <= '0;
         r_err_cnt  <= '0;
      end else begin
         case (r_state)
            StIdle: begin
               if (!cmd_empty_i) begin
                  r_state    <= StFetch;
                  r_cmd_read <= 1'b1;
                  r_busy     <= 1'b1;
               end
            end
            StFetch: begin
               r_cmd_read <= 1'b0;
               r_addr     <= cmd_rdata_i[DATA_WIDTH +: ADDR_WIDTH];
               r_wdata    <= cmd_rdata_i[DATA_WIDTH-1:0];
               if (cmd_rdata_i[CMD_WIDTH-1]) begin
                  r_arvalid <= 1'b1;
                  r_state   <= StRaddr;
               end else begin
                  r_awvalid <= 1'b1;
                  r_wvalid  <= 1'b1;
                  r_state   <= StWaddr;
               end
            end
            StWaddr: begin
               if (m_axi_awready) r_awvalid <= 1'b0;
               if (m_axi_wready)  r_wvalid  <= 1'b0;
               if (w_aw_done && w_w_done) begin
                  r_bready <= 1'b1;
                  r_state  <= StWresp;
               end
            end
            StWresp: begin
               if (m_axi_bvalid) begin
                  r_bready <= 1'b0;
                  r_rsp    <= {m_axi_bresp, {DATA_WIDTH{1'b0}}};
                  r_state  <= StPush;
               end
            end
            StRaddr: begin
               if (m_axi_arready) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
                  r_state   <= StRdata;
               end
            end
            StRdata: begin
               if (m_axi_rvalid) begin
                  r_rready <= 1'b0;
                  r_rsp    <= {m_axi_rresp, m_axi_rdata};
                  r_state  <= StPush;
               end
            end
            StPush: begin
               if (!rsp_full_i) begin
                  r_state   <= StIdle;
                  r_busy    <= 1'b0;
                  r_txn_cnt <= r_txn_cnt + 16'd1;
                  if ((r_rsp[RSP_WIDTH-1 -: 2] != 2'b00) && (r_err_cnt != 16'hFFFF)) begin
                     r_err_cnt <= r_err_cnt + 16'd1;
                  end
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign cmd_read_o    = r_cmd_read;
   assign rsp_wdata_o   = r_rsp;
   assign rsp_write_o   = w_push;
   assign m_axi_awaddr  = r_addr;
   assign m_axi_awprot  = 3'b000;
   assign m_axi_awvalid = r_awvalid;
   assign m_axi_wdata   = r_wdata;
   assign m_axi_wstrb   = '1;
   assign m_axi_wvalid  = r_wvalid;
   assign m_axi_bready  = r_bready;
   assign m_axi_araddr  = r_addr;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_arvalid = r_arvalid;
   assign m_axi_rready  = r_rready;
   assign busy_o        = r_busy;
   assign txn_count_o   = r_txn_cnt;
   assign err_count_o   = r_err_cnt;

endmodule

// File: tb/tb_axi_lite_cmd_engine.sv
// Bench for axi_lite_cmd_engine: command FIFO and memory-backed AXI-Lite slave around the DUT,
// responses compared against an in-order memory model of the command stream.
module tb_axi_lite_cmd_engine;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned CW = 1 + AW + DW;
   localparam int unsigned RW = 2 + DW;

   logic          aclk = 1'b0;
   logic          resetn = 1'b0;
   logic [CW-1:0] cmd_rdata_i;
   logic          cmd_empty_i;
   logic          cmd_read_o;
   logic [RW-1:0] rsp_wdata_o;
   logic          rsp_write_o;
   logic          rsp_full_i;
   logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
   logic [2:0]    m_axi_awprot, m_axi_arprot;
   logic          m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
   logic [DW-1:0] m_axi_wdata, m_axi_rdata;
   logic [DW/8-1:0] m_axi_wstrb;
   logic [1:0]    m_axi_bresp, m_axi_rresp;
   logic          m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
   logic          m_axi_rvalid, m_axi_rready;
   logic          busy_o;
   logic [15:0]   txn_count_o, err_count_o;

   always #5 aclk = ~aclk;

   axi_lite_cmd_engine #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW)
   ) dut (
      .aclk(aclk), .resetn(resetn),
      .cmd_rdata_i(cmd_rdata_i), .cmd_empty_i(cmd_empty_i), .cmd_read_o(cmd_read_o),
      .rsp_wdata_o(rsp_wdata_o), .rsp_write_o(rsp_write_o), .rsp_full_i(rsp_full_i),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
      .busy_o(busy_o), .txn_count_o(txn_count_o), .err_count_o(err_count_o)
   );

   int total = 0;
   int bad   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   int cyc = 0;
   always @(posedge aclk) cyc <= cyc + 1;

   // Command FIFO with registered read data, flushed by the shared reset.
   logic [CW-1:0] cmd_mem [0:255];
   int wr_ptr = 0;
   int rd_ptr = 0;
   assign cmd_empty_i = (rd_ptr == wr_ptr);
   always @(posedge aclk) begin
      cmd_rdata_i <= cmd_mem[rd_ptr[7:0]];
      if (!resetn) rd_ptr <= wr_ptr;
      else if (cmd_read_o && (rd_ptr != wr_ptr)) rd_ptr <= rd_ptr + 1;
   end

   // Reference model: memory semantics applied to commands in issue order.
   logic [DW-1:0] model_mem [logic [AW-1:0]];
   logic [DW-1:0] smem      [logic [AW-1:0]];
   logic [RW-1:0] exp_q [$];
   logic [15:0]   exp_txn = 0;
   logic [15:0]   exp_err = 0;

   function automatic logic [1:0] resp_of(input logic [AW-1:0] a);
      return (a[7:4] == 4'hE) ? 2'b10 : 2'b00;
   endfunction

   task automatic push_cmd(input logic rnw, input logic [AW-1:0] a, input logic [DW-1:0] d);
      logic [DW-1:0] rd;
      cmd_mem[wr_ptr[7:0]] = {rnw, a, d};
      if (rnw) begin
         rd = model_mem.exists(a) ? model_mem[a] : ~a;
         exp_q.push_back({resp_of(a), rd});
      end else begin
         model_mem[a] = d;
         exp_q.push_back({resp_of(a), {DW{1'b0}}});
      end
      exp_txn = exp_txn + 16'd1;
      if (resp_of(a) != 2'b00 && exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
      wr_ptr = wr_ptr + 1;
   endtask

   // Slave configuration: fixed ready/response delays, or random ones in rand_mode.
   int cfg_aw = 0, cfg_w = 0, cfg_ar = 0, cfg_b = 0, cfg_r = 0;
   bit rand_mode = 0, rand_bp = 0, full_force = 0;

   function automatic int pick(input int c);
      return rand_mode ? int'($urandom_range(0, 3)) : c;
   endfunction

   logic [AW-1:0] cur_addr;
   logic [DW-1:0] cur_wdata;
   logic          cur_rnw;
   int aw_cyc = 0, w_cyc = 0, ar_cyc = 0;
   int pops = 0, pushes = 0;
   int last_pop_cyc = -100, last_push_cyc = -100;

   initial begin : slave
      bit aw_hs, w_hs, ar_hs, b_hs, r_hs, rst_s;
      bit aw_hold, w_hold, ar_hold, aw_got, w_got, ar_got;
      int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
      logic [AW-1:0] s_awaddr, s_araddr;
      logic [DW-1:0] s_wdata;
      aw_hold = 0; w_hold = 0; ar_hold = 0; aw_got = 0; w_got = 0; ar_got = 0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
      s_awaddr = '0; s_araddr = '0; s_wdata = '0;
      m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
      m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_rvalid = 0; m_axi_rresp = 0; m_axi_rdata = 0;
      rsp_full_i = 0;
      forever begin
         @(negedge aclk);
         rst_s = !resetn;
         aw_hs = m_axi_awvalid && m_axi_awready;
         w_hs  = m_axi_wvalid && m_axi_wready;
         ar_hs = m_axi_arvalid && m_axi_arready;
         b_hs  = m_axi_bvalid && m_axi_bready;
         r_hs  = m_axi_rvalid && m_axi_rready;
         if (aw_hs) s_awaddr = m_axi_awaddr;
         if (w_hs)  s_wdata  = m_axi_wdata;
         if (ar_hs) s_araddr = m_axi_araddr;
         if (rst_s) begin
            aw_hold = 0; w_hold = 0; ar_hold = 0;
         end else begin
            if (aw_hold) check_eq("aw_hold", m_axi_awvalid, 1);
            if (w_hold)  check_eq("w_hold", m_axi_wvalid, 1);
            if (ar_hold) check_eq("ar_hold", m_axi_arvalid, 1);
            if (cmd_read_o) begin
               check_eq("pop_nonempty", cmd_empty_i, 0);
               check_eq("fetch_gap", (cyc - last_push_cyc) >= 2, 1);
               {cur_rnw, cur_addr, cur_wdata} = cmd_mem[rd_ptr[7:0]];
               pops++; last_pop_cyc = cyc;
               aw_cyc = 0; w_cyc = 0; ar_cyc = 0;
               aw_cnt = pick(cfg_aw); w_cnt = pick(cfg_w); ar_cnt = pick(cfg_ar);
               b_cnt = pick(cfg_b); r_cnt = pick(cfg_r);
            end
            if (m_axi_awvalid) begin
               aw_cyc++;
               check_eq("awaddr", m_axi_awaddr, cur_addr);
               check_eq("awprot", m_axi_awprot, 0);
            end
            if (m_axi_wvalid) begin
               w_cyc++;
               check_eq("wdata", m_axi_wdata, cur_wdata);
               check_eq("wstrb", m_axi_wstrb, 4'hF);
            end
            if (m_axi_arvalid) begin
               ar_cyc++;
               check_eq("araddr", m_axi_araddr, cur_addr);
               check_eq("arprot", m_axi_arprot, 0);
            end
            if (m_axi_bready) check_eq("bready_after_aw_w", aw_got && w_got, 1);
            if (rsp_write_o) begin
               check_eq("push_not_full", rsp_full_i, 0);
               check_eq("rsp_expected", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) check_eq("rsp", rsp_wdata_o, exp_q.pop_front());
               pushes++; last_push_cyc = cyc;
            end
            aw_hold = m_axi_awvalid && !m_axi_awready;
            w_hold  = m_axi_wvalid && !m_axi_wready;
            ar_hold = m_axi_arvalid && !m_axi_arready;
         end
         @(posedge aclk);
         #1;
         if (rst_s) begin
            aw_got = 0; w_got = 0; ar_got = 0;
            m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
            m_axi_bvalid = 0; m_axi_rvalid = 0; rsp_full_i = 0;
         end else begin
            if (aw_hs) aw_got = 1;
            if (w_hs)  w_got = 1;
            if (ar_hs) ar_got = 1;
            if (b_hs) begin m_axi_bvalid = 0; aw_got = 0; w_got = 0; end
            if (r_hs) begin m_axi_rvalid = 0; ar_got = 0; end
            if (aw_got && w_got && !m_axi_bvalid) begin
               if (b_cnt == 0) begin
                  m_axi_bvalid = 1;
                  m_axi_bresp = resp_of(s_awaddr);
                  smem[s_awaddr] = s_wdata;
               end else b_cnt--;
            end
            if (ar_got && !m_axi_rvalid) begin
               if (r_cnt == 0) begin
                  m_axi_rvalid = 1;
                  m_axi_rresp = resp_of(s_araddr);
                  m_axi_rdata = smem.exists(s_araddr) ? smem[s_araddr] : ~s_araddr;
               end else r_cnt--;
            end
            m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
            if (m_axi_awvalid) begin
               if (aw_cnt == 0) m_axi_awready = 1; else aw_cnt--;
            end
            if (m_axi_wvalid) begin
               if (w_cnt == 0) m_axi_wready = 1; else w_cnt--;
            end
            if (m_axi_arvalid) begin
               if (ar_cnt == 0) m_axi_arready = 1; else ar_cnt--;
            end
            rsp_full_i = full_force || (rand_bp && ($urandom_range(0, 3) == 0));
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge aclk);
      #1;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while ((exp_q.size() != 0 || busy_o || !cmd_empty_i) && n < 2000) begin
         @(negedge aclk);
         n++;
      end
      @(negedge aclk);
      check_eq(tag, exp_q.size(), 0);
      check_eq({tag, "_txn"}, txn_count_o, exp_txn);
      check_eq({tag, "_err"}, err_count_o, exp_err);
      check_eq({tag, "_idle"}, busy_o, 0);
      step(1);
   endtask

   task automatic check_quiet(input string tag);
      check_eq({tag, "_busy"}, busy_o, 0);
      check_eq({tag, "_valids"}, {m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                                  m_axi_arvalid, m_axi_rready, cmd_read_o, rsp_write_o}, 0);
      check_eq({tag, "_txn"}, txn_count_o, 0);
      check_eq({tag, "_err"}, err_count_o, 0);
      check_eq({tag, "_rsp"}, rsp_wdata_o, 0);
   endtask

   initial begin : main
      int c0, p0;
      logic [AW-1:0] a;
      smem[32'h20] = 32'h1234_5678;
      model_mem[32'h20] = 32'h1234_5678;
      resetn = 0;
      step(3);
      @(negedge aclk);
      check_quiet("reset");
      step(1);
      resetn = 1;
      step(2);

      c0 = cyc;
      push_cmd(0, 32'h10, 32'hDEAD_BEEF);
      drain("wr");
      check_eq("wr_pop_lat", last_pop_cyc - c0, 1);
      check_eq("wr_rsp_lat", last_push_cyc - c0, 4);

      cfg_ar = 3;
      push_cmd(1, 32'h20, 32'h0);
      drain("rd");
      check_eq("rd_arvalid_cycles", ar_cyc, 4);
      cfg_ar = 0;

      cfg_aw = 3;
      push_cmd(0, 32'h50, 32'hCAFE_F00D);
      drain("split");
      check_eq("split_aw_cycles", aw_cyc, 4);
      check_eq("split_w_cycles", w_cyc, 1);
      cfg_aw = 0;

      push_cmd(1, 32'hE0, 32'h0);
      drain("err");

      p0 = pushes;
      full_force = 1;
      push_cmd(1, 32'h50, 32'h0);
      step(5);
      @(negedge aclk);
      check_eq("bp_head", rsp_wdata_o, exp_q[0]);
      step(5);
      @(negedge aclk);
      check_eq("bp_stable", rsp_wdata_o, exp_q[0]);
      check_eq("bp_nopush", pushes, p0);
      check_eq("bp_busy", busy_o, 1);
      step(1);
      full_force = 0;
      drain("bp");
      check_eq("bp_one_push", pushes, p0 + 1);

      rand_mode = 1;
      p0 = pops;
      for (int i = 0; i < 8; i++) begin
         a = 32'h100 + 32'($urandom_range(0, 15)) * 32'd16;
         push_cmd(logic'(i % 2), a, $urandom);
      end
      drain("b2b");
      check_eq("b2b_pops", pops - p0, 8);
      rand_mode = 0;

      cfg_b = 5;
      push_cmd(0, 32'h30, 32'h1111_2222);
      c0 = 0;
      while (!m_axi_bready && c0 < 50) begin
         @(negedge aclk);
         c0++;
      end
      check_eq("rst_saw_bready", m_axi_bready, 1);
      step(1);
      resetn = 0;
      step(1);
      @(negedge aclk);
      check_quiet("rst_mid");
      step(1);
      resetn = 1;
      exp_q.delete();
      exp_txn = 0;
      exp_err = 0;
      cfg_b = 0;
      step(2);
      push_cmd(1, 32'h10, 32'h0);
      drain("post_rst");

      rand_mode = 1;
      rand_bp = 1;
      for (int i = 0; i < 40; i++) begin
         a = 32'h100 + 32'($urandom_range(0, 15)) * 32'd16;
         push_cmd(logic'($urandom_range(0, 1)), a, $urandom);
         step(int'($urandom_range(1, 6)));
      end
      drain("rand");
      rand_bp = 0;
      rand_mode = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
